// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl - hazard and sequencing controller for the 5-stage core.
//
// Decides, every cycle, which pipeline registers hold and which load a bubble.
// Hold/flush outputs are combinational from the registered FSM state plus the
// current hazard inputs; the FSM, wait counter and drain counter are
// registered.
//
// Parameters:
//   MEM_TIMEOUT  - consecutive data-memory wait cycles tolerated before the
//                  controller enters FAULT (2..255)
//   DRAIN_CYCLES - fetch bubbles inserted after a halt request before
//                  `halted` is reported (1..15)
//
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_uses_*  source operands of the instruction in ID
//   ex_rd, ex_write_reg,
//   ex_read_mem               destination info of the instruction in EX
//   ex_branch_taken           EX resolved a taken branch/jump
//   mem_req, mem_ready        data-memory handshake of the MEM stage
//   halt_req                  external halt request (level)
//   pc_hold .. mem_wb_flush   hold/flush controls for the pipeline registers
//   halted                    core halted and drained
//   fault                     memory timeout, sticky until rst
//
// Optional feature (macro PIPE_CTRL_PERF_EN): adds the 32-bit wrapping
// counters perf_stall_cycles, perf_flush_count and perf_loaduse_count.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_write_reg,
    input  logic        ex_read_mem,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_flush,
    output logic        ex_mem_hold,
    output logic        mem_wb_flush,
    output logic        halted,
    output logic        fault
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_loaduse_count
`endif
);

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StMemWait,
        StDrain,
        StHalted,
        StFault
    } state_e;

    localparam logic [8:0] TimeoutLim = 9'(MEM_TIMEOUT);
    localparam logic [3:0] DrainLast  = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    // Remembers whether the current memory wait interrupted a drain.
    logic        from_drain_q, from_drain_d;

    logic        load_use;
    logic        mem_stall;
    logic        freeze;     // memory freeze of the whole front end
    logic        decode;     // branch/load-use decode is live this cycle
    logic        drain_ovl;  // drain bubbles forced on top of the decode
    logic        br_flush;
    logic        lu_stall;
    logic        drain_tick;
    logic [8:0]  wait_inc;

    assign load_use = ex_read_mem & ex_write_reg & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready;
    assign wait_inc  = {1'b0, wait_cnt_q} + 9'd1;

    // ------------------------------------------------------------------
    // Hold / flush outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        freeze       = 1'b0;
        decode       = 1'b0;
        drain_ovl    = 1'b0;

        unique case (state_q)
            StInit: begin
                pc_hold      = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                mem_wb_flush = 1'b1;
            end
            StRun: begin
                if (mem_stall) freeze = 1'b1;
                else           decode = 1'b1;
            end
            StDrain: begin
                if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    decode    = 1'b1;
                    drain_ovl = 1'b1;
                end
            end
            StMemWait: begin
                // The release cycle already decodes branch/load-use.
                if (!mem_ready) begin
                    freeze = 1'b1;
                end else begin
                    decode    = 1'b1;
                    drain_ovl = from_drain_q;
                end
            end
            StHalted: begin
                pc_hold     = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                halted      = 1'b1;
            end
            StFault: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                mem_wb_flush = 1'b1;
                fault        = 1'b1;
            end
            default: begin
                pc_hold      = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                mem_wb_flush = 1'b1;
            end
        endcase

        // A taken branch squashes the wrong-path instruction in ID, so a
        // simultaneous load-use on it is irrelevant.
        br_flush = decode & ex_branch_taken;
        lu_stall = decode & ~ex_branch_taken & load_use;

        if (freeze) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
        end
        if (br_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
        if (lu_stall) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
        end
        // While draining, fetch stops and IF/ID takes a bubble; a bubble
        // overrides any IF/ID hold requested by a load-use.
        if (drain_ovl) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
            if_id_hold  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        from_drain_d = from_drain_q;
        drain_tick   = 1'b0;

        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (mem_stall) begin
                    state_d      = StMemWait;
                    wait_cnt_d   = 8'd1;
                    from_drain_d = 1'b0;
                end else if (halt_req) begin
                    state_d     = StDrain;
                    drain_cnt_d = 4'd0;
                end
            end
            StDrain: begin
                if (mem_stall) begin
                    state_d      = StMemWait;
                    wait_cnt_d   = 8'd1;
                    from_drain_d = 1'b1;
                end else begin
                    drain_tick = 1'b1;
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    if (wait_inc >= TimeoutLim) state_d = StFault;
                    else                        wait_cnt_d = wait_inc[7:0];
                end else if (from_drain_q) begin
                    // Release cycle is a non-stalled drain cycle.
                    drain_tick = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StHalted: begin
                if (!halt_req) state_d = StRun;
            end
            StFault: state_d = StFault;
            default: state_d = StInit;
        endcase

        if (drain_tick) begin
            if (!halt_req) begin
                state_d = StRun;
            end else if (drain_cnt_q == DrainLast) begin
                state_d = StHalted;
            end else begin
                state_d     = StDrain;
                drain_cnt_d = drain_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StInit;
            wait_cnt_q   <= 8'd0;
            drain_cnt_q  <= 4'd0;
            from_drain_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            from_drain_q <= from_drain_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cyc_q, flush_cnt_q, lu_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            lu_cnt_q    <= 32'd0;
        end else begin
            if (freeze)   stall_cyc_q <= stall_cyc_q + 32'd1;
            if (br_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (lu_stall) lu_cnt_q    <= lu_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cycles  = stall_cyc_q;
    assign perf_flush_count   = flush_cnt_q;
    assign perf_loaduse_count = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl - directed self-checking bench for pipe_ctrl.
// Output vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
// id_ex_flush, ex_mem_hold, mem_wb_flush, halted, fault}.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_write_reg, ex_read_mem, ex_branch_taken;
    logic       mem_req, mem_ready, halt_req;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic       ex_mem_hold, mem_wb_flush, halted, fault;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count, perf_loaduse_count;
`endif

    int nvec = 0;
    int nerr = 0;

    localparam logic [8:0] VIdle  = 9'b000000000;
    localparam logic [8:0] VInit  = 9'b101010100;
    localparam logic [8:0] VLu    = 9'b110010000;
    localparam logic [8:0] VBr    = 9'b001010000;
    localparam logic [8:0] VFrz   = 9'b110101100;
    localparam logic [8:0] VFault = 9'b110101101;
    localparam logic [8:0] VDrain = 9'b101000000;
    localparam logic [8:0] VDrBr  = 9'b101010000;
    localparam logic [8:0] VHalt  = 9'b101010010;

    pipe_ctrl #(
        .MEM_TIMEOUT (16),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_write_reg   (ex_write_reg),
        .ex_read_mem    (ex_read_mem),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .halt_req       (halt_req),
        .pc_hold        (pc_hold),
        .if_id_hold     (if_id_hold),
        .if_id_flush    (if_id_flush),
        .id_ex_hold     (id_ex_hold),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_hold    (ex_mem_hold),
        .mem_wb_flush   (mem_wb_flush),
        .halted         (halted),
        .fault          (fault)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
        .perf_loaduse_count(perf_loaduse_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        #1;
        obs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
               ex_mem_hold, mem_wb_flush, halted, fault};
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_write_reg = 1'b0; ex_read_mem = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic set_lu_rs2(input logic [4:0] rd);
        ex_read_mem = 1'b1; ex_write_reg = 1'b1; ex_rd = rd;
        id_rs2 = rd; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        #1;
        chk("reset", VInit);
        rst = 1'b0;
        chk("init_cycle", VInit);
        tick();
        chk("run_idle", VIdle);

        // Load-use on rs2, then the load advances to MEM.
        set_lu_rs2(5'd5);
        chk("lu_rs2", VLu);
        tick();
        clear_in();
        chk("lu_one_cycle", VIdle);
        set_lu_rs2(5'd0);
        chk("lu_rd_zero", VIdle);
        clear_in();
        // Load-use on rs1; same match with use flag low must not stall.
        ex_read_mem = 1'b1; ex_write_reg = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        id_uses_rs1 = 1'b1;
        chk("lu_rs1", VLu);
        id_uses_rs1 = 1'b0;
        chk("lu_unused", VIdle);
        id_uses_rs1 = 1'b1; ex_write_reg = 1'b0;
        chk("lu_no_write", VIdle);
        clear_in();
        tick();

        // Branch beats a simultaneous load-use.
        set_lu_rs2(5'd9);
        ex_branch_taken = 1'b1;
        chk("br_over_lu", VBr);
        tick();
        clear_in();
        chk("br_one_cycle", VIdle);

        // Memory stall for three cycles with a taken branch held.
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        chk("mstall_c1", VFrz);
        tick();
        chk("mstall_c2", VFrz);
        tick();
        chk("mstall_c3", VFrz);
        tick();
        mem_ready = 1'b1;
        chk("mstall_release", VBr);
        tick();
        clear_in();
        chk("mstall_back_run", VIdle);

        // Timeout: 16 wait cycles, then FAULT.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("timeout_freeze", VFrz);
            tick();
        end
        chk("timeout_fault", VFault);
        mem_ready = 1'b1; mem_req = 1'b0;
        chk("fault_ready", VFault);
        tick();
        clear_in();
        chk("fault_sticky", VFault);
        rst = 1'b1;
        chk("fault_rst", VInit);
        rst = 1'b0;
        tick();
        chk("post_rst_run", VIdle);

        // Halt: four drain cycles, halted on the fifth clock.
        halt_req = 1'b1;
        chk("halt_sample", VIdle);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("drain", VDrain);
        end
        tick();
        chk("halted", VHalt);
        halt_req = 1'b0;
        chk("halted_hold", VHalt);
        tick();
        chk("unhalt_run", VIdle);

        // Drop halt mid-drain: back to RUN, never halted.
        halt_req = 1'b1;
        tick();
        chk("drain2_c1", VDrain);
        ex_branch_taken = 1'b1;
        chk("drain_branch", VDrBr);
        ex_branch_taken = 1'b0;
        tick();
        halt_req = 1'b0;
        chk("drain2_c2", VDrain);
        tick();
        chk("drain_abort_run", VIdle);
        tick();
        tick();
        tick();
        chk("no_halt_pulse", VIdle);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
